// File: rtl/injector_pulse_gen.sv
// Injector pulse scheduler: start delay, tick-counted enable width and
// enforced dead time, feeding the peak/hold select stage.
module injector_pulse_gen #(
  parameter int c_WIDTH   = 16,
  parameter int c_MIN_OFF = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic [c_WIDTH-1:0] i_delay,
  input  logic [c_WIDTH-1:0] i_width,
  input  logic               i_abort,
  input  logic               i_clearErr,
  output logic               o_enable,
  output logic               o_ready,
  output logic               o_pulseDone,
  output logic               o_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ON,
    OFF
  } state_t;

  localparam logic [c_WIDTH-1:0] c_OFF_CNT = c_WIDTH'(c_MIN_OFF);
  localparam logic [c_WIDTH-1:0] c_ONE     = c_WIDTH'(1);

  state_t             state;
  logic [c_WIDTH-1:0] cnt;
  logic [c_WIDTH-1:0] width_q;
  logic               pulse_done;
  logic               overrun;

  assign o_enable    = (state == ON);
  assign o_ready     = (state == IDLE);
  assign o_pulseDone = pulse_done;
  assign o_overrun   = overrun;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      width_q    <= '0;
      pulse_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pulse_done <= 1'b0;

      // a dropped request outranks a same-cycle clear
      if (i_start && state != IDLE)
        overrun <= 1'b1;
      else if (i_clearErr)
        overrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (i_start) begin
            width_q <= i_width;
            if (i_width == '0) begin
              pulse_done <= 1'b1;
            end else if (i_delay == '0) begin
              state <= ON;
              cnt   <= i_width;
            end else begin
              state <= DELAY;
              cnt   <= i_delay;
            end
          end
        end

        DELAY: begin
          if (i_abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (i_tick) begin
            if (cnt == c_ONE) begin
              state <= ON;
              cnt   <= width_q;
            end else begin
              cnt <= cnt - c_ONE;
            end
          end
        end

        ON: begin
          if (i_abort || (i_tick && cnt == c_ONE)) begin
            pulse_done <= 1'b1;
            if (c_MIN_OFF > 0) begin
              state <= OFF;
              cnt   <= c_OFF_CNT;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else if (i_tick) begin
            cnt <= cnt - c_ONE;
          end
        end

        OFF: begin
          if (i_tick) begin
            if (cnt == c_ONE) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - c_ONE;
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_injector_pulse_gen.sv
// Scoreboard bench for injector_pulse_gen: per-cycle expected outputs
// are queued by the stimulus and checked by an independent monitor.
module tb_injector_pulse_gen;

  logic        clk;
  logic        i_reset;
  logic        i_tick;
  logic        i_start;
  logic [15:0] i_delay;
  logic [15:0] i_width;
  logic        i_abort;
  logic        i_clearErr;
  logic        o_enable;
  logic        o_ready;
  logic        o_pulseDone;
  logic        o_overrun;

  injector_pulse_gen #(
    .c_WIDTH  (16),
    .c_MIN_OFF(4)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_start    (i_start),
    .i_delay    (i_delay),
    .i_width    (i_width),
    .i_abort    (i_abort),
    .i_clearErr (i_clearErr),
    .o_enable   (o_enable),
    .o_ready    (o_ready),
    .o_pulseDone(o_pulseDone),
    .o_overrun  (o_overrun)
  );

  typedef struct {
    logic [3:0] exp;
    string      name;
    int         c;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done_stim = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected vector is {enable, ready, pulseDone, overrun}
  task automatic cyc(input string nm, input int c,
                     input logic st, input logic [15:0] d,
                     input logic [15:0] w, input logic tk,
                     input logic ab, input logic ce,
                     input logic rs, input logic [3:0] e);
    @(posedge clk);
    #1;
    i_start    = st;
    i_delay    = d;
    i_width    = w;
    i_tick     = tk;
    i_abort    = ab;
    i_clearErr = ce;
    i_reset    = rs;
    q.push_back('{e, nm, c});
  endtask

  // monitor: outputs are presented every cycle
  initial begin
    exp_t       x;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = {o_enable, o_ready, o_pulseDone, o_overrun};
        checks++;
        if (act !== x.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d en/rdy/done/ovr got=%b exp=%b",
                   x.name, x.c, act, x.exp);
        end
      end
    end
  end

  initial begin
    i_reset    = 1'b1;
    i_tick     = 1'b1;
    i_start    = 1'b0;
    i_delay    = '0;
    i_width    = '0;
    i_abort    = 1'b0;
    i_clearErr = 1'b0;
    repeat (2) @(posedge clk);

    cyc("reset", 0, 0, 16'd0, 16'd0, 1, 0, 0, 0, 4'b0100);

    for (int c = 0; c <= 11; c++)
      cyc("basic", c, c == 0, 16'd0, 16'd5, 1, 0, 0, 0,
          {c >= 1 && c <= 5, c == 0 || c >= 10, c == 6, 1'b0});

    for (int c = 0; c <= 11; c++)
      cyc("delay", c, c == 0, 16'd3, 16'd2, 1, 0, 0, 0,
          {c >= 4 && c <= 5, c == 0 || c >= 10, c == 6, 1'b0});

    for (int c = 0; c <= 29; c++)
      cyc("sparse", c, c == 0, 16'd0, 16'd3, c % 4 == 3, 0, 0, 0,
          {c >= 1 && c <= 11, c == 0 || c >= 28, c == 12, 1'b0});

    for (int c = 0; c <= 13; c++)
      cyc("overrun", c, c == 0 || c == 3, 16'd0, 16'd5, 1, 0,
          c == 3 || c == 12, 0,
          {c >= 1 && c <= 5, c == 0 || c >= 10, c == 6,
           c >= 4 && c <= 12});

    for (int c = 0; c <= 9; c++)
      cyc("abort_on", c, c == 0, 16'd0, 16'd10, 1, c == 3, 0, 0,
          {c >= 1 && c <= 3, c == 0 || c >= 8, c == 4, 1'b0});

    for (int c = 0; c <= 2; c++)
      cyc("width0", c, c == 0, 16'd5, 16'd0, 1, 0, 0, 0,
          {1'b0, 1'b1, c == 1, 1'b0});

    for (int c = 0; c <= 5; c++)
      cyc("abort_dly", c, c == 0, 16'hFFFF, 16'd3, 1, c == 2, 0, 0,
          {1'b0, c == 0 || c >= 3, 1'b0, 1'b0});

    for (int c = 0; c <= 3; c++)
      cyc("reset_on", c, c == 0 || c == 1, 16'd0, 16'd10, 1, 0, 0,
          c == 2,
          {c >= 1 && c <= 2, c == 0 || c == 3, 1'b0, c == 2});

    for (int c = 0; c <= 8; c++)
      cyc("after_rst", c, c == 0, 16'd1, 16'd1, 1, 0, 0, 0,
          {c == 2, c == 0 || c >= 7, c == 3, 1'b0});

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/injector_pulse_gen.md
Name: injector_pulse_gen

Overview:
Per-channel injector pulse scheduler, directly upstream of the peak/hold select stage.
- Accepts a one-cycle fire request carrying a start delay and a pulse width, both in divided-clock ticks.
- Produces the injector enable level; the enable's rising edge starts the peak/hold select count, and its fall clears that count.
- Enforces a minimum dead time between pulses.
- Flags requests that arrive while a pulse is in progress.

Parameters:
- c_WIDTH, 16, width of the delay, width and dead-time counters.
- c_MIN_OFF, 4, dead-time ticks after every pulse before a new request is accepted; 0 means no dead time.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  divided-clock tick enable; counters advance only on cycles with i_tick=1.
- i_start  in  1  fire request, sampled only when o_ready=1.
- i_delay  in  c_WIDTH  ticks from acceptance to enable rise; latched on accept.
- i_width  in  c_WIDTH  enable high time in ticks; latched on accept.
- i_abort  in  1  terminate the current pulse or delay.
- i_clearErr  in  1  clears o_overrun.
- o_enable  out  1  injector enable, drives the peak/hold select enable.
- o_ready  out  1  idle, request accepted this cycle.
- o_pulseDone  out  1  one-cycle completion strobe.
- o_overrun  out  1  sticky: request dropped while busy.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE; o_enable=0, o_ready=1, o_pulseDone=0, o_overrun=0; counter=0.
- Outputs:
  - All outputs are registered or decoded from registered state only.
  - o_enable=(state==ON); o_ready=(state==IDLE).
- States: IDLE, DELAY, ON, OFF. The single down-counter is reloaded on each state entry.
- IDLE:
  - i_start=1 latches i_delay and i_width. This transition is not gated by i_tick.
  - i_width==0: stay IDLE; o_pulseDone=1 next cycle; o_enable never rises.
  - else i_delay==0: go to ON, counter=i_width.
  - else: go to DELAY, counter=i_delay.
- DELAY / ON / OFF common rule, on each cycle with i_tick=1:
  - counter==1: exit the state.
  - else: counter decrements.
  - i_tick=0: counter holds.
- DELAY exit: go to ON, counter=latched width.
- ON exit:
  - c_MIN_OFF>0: go to OFF, counter=c_MIN_OFF.
  - c_MIN_OFF==0: go to IDLE.
  - o_pulseDone=1 in the first cycle after o_enable falls.
- OFF exit: go to IDLE.
- Timing with i_tick held at 1 and start in cycle 0:
  - o_enable high in cycles delay+1 .. delay+width (exactly width cycles).
  - o_ready returns in cycle delay+width+c_MIN_OFF+1.
- Tick gating: with sparse ticks, enable high time equals exactly width tick events, each counted in the cycle it occurs.
- i_abort (has priority over i_start and counter exit in the same cycle):
  - In DELAY: go to IDLE; no pulse; no pulseDone.
  - In ON: go to OFF (or IDLE if c_MIN_OFF==0); o_enable falls next cycle; o_pulseDone=1. Dead time is still enforced.
  - In IDLE or OFF: no effect.
- Overrun:
  - i_start=1 while o_ready=0 is ignored and sets o_overrun=1.
  - i_clearErr clears it; a set in the same cycle wins over the clear.
- Arithmetic: counters are unsigned c_WIDTH bits and never wrap. The maximum value 2^c_WIDTH-1 is valid.
- Reset mid-pulse: o_enable=0 in the cycle after reset is sampled. No o_pulseDone is generated.

Test Plan:
- i_tick=1, c_MIN_OFF=4, start in cycle 0 with delay=0, width=5:
  - o_enable=1 in cycles 1-5.
  - o_pulseDone in cycle 6.
  - o_ready=0 in cycles 1-9, o_ready=1 in cycle 10.
- delay=3, width=2, i_tick=1:
  - state DELAY in cycles 1-3.
  - o_enable=1 in cycles 4-5; o_pulseDone in cycle 6.
- i_tick every 4th cycle, delay=0, width=3:
  - o_enable stays high until the 3rd tick after acceptance, then falls the following cycle.
  - Counter holds between ticks.
- i_start pulsed in cycle 3 during a width=5 pulse:
  - The pulse is unaffected and o_overrun=1.
  - i_clearErr in cycle 12 gives o_overrun=0 in cycle 13.
- i_abort in cycle 3 of ON (delay=0, width=10):
  - o_enable=0 from cycle 4; o_pulseDone in cycle 4.
  - o_ready returns 4 cycles after OFF entry.
  - Also: width=0 gives only o_pulseDone with no enable, and abort during DELAY gives no pulseDone.
- i_reset in cycle 2 of ON:
  - Next cycle: o_enable=0, o_ready=1, o_overrun=0, o_pulseDone=0.
  - A new start is then accepted normally.
